// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage
// and a line-based data memory. Hits are zero-stall; misses evict dirty victims and refill.
module dcache_wb #(
  parameter int unsigned LINES  = 8,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned ADDR_W = 30
) (
  input  logic                               clk,
  input  logic                               i_rst,
  input  logic                               proc_read,
  input  logic                               proc_write,
  input  logic [ADDR_W-1:0]                  proc_addr,
  input  logic [31:0]                        proc_wdata,
  output logic [31:0]                        proc_rdata,
  output logic                               proc_stall,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [ADDR_W-$clog2(WORDS)-1:0]    mem_addr,
  output logic [32*WORDS-1:0]                mem_wdata,
  input  logic [32*WORDS-1:0]                mem_rdata,
  input  logic                               mem_ready
);

  localparam int unsigned IDX    = $clog2(LINES);
  localparam int unsigned OFF    = $clog2(WORDS);
  localparam int unsigned TAG    = ADDR_W - IDX - OFF;
  localparam int unsigned LINE_W = 32 * WORDS;
  localparam int unsigned OFF_W  = (OFF == 0) ? 1 : OFF;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG-1:0]      tag_q  [LINES];
  logic [TAG-1:0]      tag_d  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic [LINE_W-1:0]   data_d [LINES];

  logic [TAG-1:0]      req_tag;
  logic [IDX-1:0]      req_idx;
  logic [OFF_W-1:0]    req_off;
  logic [31:0]         word_base;
  logic                req_active;
  logic                hit;

  assign req_tag = proc_addr[ADDR_W-1 -: TAG];
  assign req_idx = proc_addr[OFF +: IDX];

  // Single-word lines have no offset field.
  if (OFF == 0) begin : g_no_off
    assign req_off = '0;
  end else begin : g_off
    assign req_off = proc_addr[OFF_W-1:0];
  end

  assign word_base  = 32'(req_off) * 32'd32;
  assign req_active = proc_read | proc_write;
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Next state, line updates and all outputs.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_COMPARE: begin
        if (req_active) begin
          if (hit) begin
            if (proc_write) begin
              data_d[req_idx][word_base +: 32] = proc_wdata;
              dirty_d[req_idx]                 = 1'b1;
            end else begin
              proc_rdata = data_q[req_idx][word_base +: 32];
            end
          end else begin
            proc_stall = 1'b1;
            state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[req_idx], req_idx};
        mem_wdata  = data_q[req_idx];
        if (mem_ready) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag, req_idx};
        if (mem_ready) begin
          data_d[req_idx]  = mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = S_COMPARE;
        end
      end
      default: state_d = S_COMPARE;
    endcase
  end

  // Control state; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q <= S_COMPARE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: a transaction-level cache/memory model predicts every
// cycle's outputs, and literal checks pin stall counts, write-back contents and addresses.
module tb_dcache_wb;

  localparam int unsigned LINES  = 8;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned ADDR_W = 30;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          proc_read = 1'b0;
  logic          proc_write = 1'b0;
  logic [29:0]   proc_addr = '0;
  logic [31:0]   proc_wdata = '0;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;

  dcache_wb #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .i_rst(i_rst),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cache contents plus backing memory
  bit            mv [8];
  bit            mdirty [8];
  int unsigned   mt [8];
  logic [127:0]  mdat [8];
  logic [127:0]  mem_m [int unsigned];

  // Per-cycle expectations
  bit            exp_on = 1'b0;
  bit            exp_stall, exp_mr, exp_mw;
  logic [27:0]   exp_maddr;
  logic [127:0]  exp_mwdata;
  logic [31:0]   exp_rdata;

  // Observations for literal checks
  int            stall_seen = 0, mr_seen = 0, mw_seen = 0;
  logic [27:0]   wb_addr = '1, al_addr = '1;
  logic [127:0]  wb_data = '0;
  logic [31:0]   rd_seen = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input int unsigned la);
    logic [127:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hC0DE0000 | 32'(la << 4) | 32'(w);
    return l;
  endfunction

  task automatic set_exp(input bit s, input bit mr, input bit mw, input int unsigned a,
                         input logic [127:0] d, input logic [31:0] r);
    exp_stall = s; exp_mr = mr; exp_mw = mw;
    exp_maddr = 28'(a); exp_mwdata = d; exp_rdata = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    proc_read = 1'b0; proc_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_exp(0, 0, 0, 0, '0, '0);
      mem_ready = rdy;
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mdirty[i] = 1'b0; end
  endtask

  // One CPU access: model decides hit / clean miss / dirty miss and schedules expectations.
  task automatic access(input bit rd, input bit wr, input int unsigned addr,
                        input logic [31:0] wd, input int unsigned wdly, input int unsigned adly);
    int unsigned tg, ix, of, la, vla;
    bit hit;
    tg = addr >> 5; ix = (addr >> 2) & 7; of = addr & 3; la = addr >> 2;
    proc_read = rd; proc_write = wr; proc_addr = 30'(addr); proc_wdata = wd;
    hit = mv[ix] && (mt[ix] == tg);
    if (!hit) begin
      set_exp(1, 0, 0, 0, '0, '0);
      step();
      if (mv[ix] && mdirty[ix]) begin
        vla = mt[ix] * 8 + ix;
        for (int c = 0; c <= int'(wdly); c++) begin
          set_exp(1, 0, 1, vla, mdat[ix], '0);
          mem_ready = (c == int'(wdly));
          step();
        end
        mem_ready = 1'b0;
        mem_m[vla] = mdat[ix];
      end
      for (int c = 0; c <= int'(adly); c++) begin
        set_exp(1, 1, 0, la, '0, '0);
        mem_rdata = mem_line(la);
        mem_ready = (c == int'(adly));
        step();
      end
      mem_ready = 1'b0;
      mdat[ix] = mem_line(la); mt[ix] = tg; mv[ix] = 1'b1; mdirty[ix] = 1'b0;
    end
    set_exp(0, 0, 0, 0, '0, (rd && !wr) ? mdat[ix][of*32 +: 32] : 32'h0);
    step();
    if (wr) begin
      mdat[ix][of*32 +: 32] = wd;
      mdirty[ix] = 1'b1;
    end
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (exp_on) begin
      chk("proc_stall", 128'(proc_stall), 128'(exp_stall));
      chk("mem_read",   128'(mem_read),   128'(exp_mr));
      chk("mem_write",  128'(mem_write),  128'(exp_mw));
      chk("mem_addr",   128'(mem_addr),   128'(exp_maddr));
      chk("mem_wdata",  mem_wdata,        exp_mwdata);
      chk("proc_rdata", 128'(proc_rdata), 128'(exp_rdata));
      if (proc_stall) stall_seen++;
      if (mem_read) begin mr_seen++; al_addr = mem_addr; end
      if (mem_write) begin mw_seen++; wb_addr = mem_addr; wb_data = mem_wdata; end
      if (proc_read && !proc_stall) rd_seen = proc_rdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int s0, mw0, mr0;
    logic [127:0] ln;
    ln = '0;
    for (int w = 0; w < 4; w++) ln[w*32 +: 32] = 32'h11 * 32'(w + 1);
    mem_m[1] = ln;
    model_reset();

    // Reset values with no request
    step();
    exp_on = 1'b1;
    set_exp(0, 0, 0, 0, '0, '0);
    step();

    // Reset held with a read pending, then cold miss on release
    exp_on = 1'b0;
    proc_read = 1'b1; proc_addr = '0;
    step(); step();
    chk("rst_hold_mread", 128'(mem_read), 128'(0));
    chk("rst_hold_mwrite", 128'(mem_write), 128'(0));
    i_rst = 1'b1; exp_on = 1'b1;
    s0 = stall_seen;
    access(1, 0, 32'h00, '0, 0, 1);
    chk("rst_cold_stalls", 128'(stall_seen - s0), 128'(3));
    chk("rst_cold_aladdr", 128'(al_addr), 128'(0));

    // Cold read miss of 0x05, R=3, then hit on 0x04
    s0 = stall_seen;
    access(1, 0, 32'h05, '0, 0, 3);
    chk("cold_stalls", 128'(stall_seen - s0), 128'(5));
    chk("cold_rdata", 128'(rd_seen), 128'(32'h22));
    s0 = stall_seen;
    access(1, 0, 32'h04, '0, 0, 0);
    chk("hit_stalls", 128'(stall_seen - s0), 128'(0));
    chk("hit_rdata", 128'(rd_seen), 128'(32'h11));

    // Write hit then conflict eviction
    s0 = stall_seen;
    access(0, 1, 32'h05, 32'hDEADBEEF, 0, 0);
    chk("whit_stalls", 128'(stall_seen - s0), 128'(0));
    s0 = stall_seen; mw0 = mw_seen;
    access(1, 0, 32'h25, '0, 2, 1);
    chk("evict_stalls", 128'(stall_seen - s0), 128'(6));
    chk("evict_wbcycles", 128'(mw_seen - mw0), 128'(3));
    chk("evict_wbaddr", 128'(wb_addr), 128'(28'h01));
    chk("evict_wbword1", 128'(wb_data[63:32]), 128'(32'hDEADBEEF));
    chk("evict_aladdr", 128'(al_addr), 128'(28'h09));

    // Write miss on clean line: only refill, then eviction writes merged word
    s0 = stall_seen; mw0 = mw_seen; mr0 = mr_seen;
    access(0, 1, 32'h42, 32'h12345678, 0, 2);
    chk("wmiss_stalls", 128'(stall_seen - s0), 128'(4));
    chk("wmiss_no_wb", 128'(mw_seen - mw0), 128'(0));
    chk("wmiss_rd_cycles", 128'(mr_seen - mr0), 128'(3));
    s0 = stall_seen;
    access(1, 0, 32'h02, '0, 0, 0);
    chk("merge_stalls", 128'(stall_seen - s0), 128'(3));
    chk("merge_wbaddr", 128'(wb_addr), 128'(28'h10));
    chk("merge_wbword2", 128'(wb_data[95:64]), 128'(32'h12345678));
    chk("merge_rdata", 128'(rd_seen), 128'(32'hC0DE0002));

    // mem_ready on the first ALLOCATE cycle, then spurious ready in COMPARE
    s0 = stall_seen;
    access(1, 0, 32'h31, '0, 0, 0);
    chk("r0_stalls", 128'(stall_seen - s0), 128'(2));
    chk("r0_rdata", 128'(rd_seen), 128'(32'hC0DE00C1));
    idle(1, 1'b1);
    idle(1, 1'b0);
    s0 = stall_seen;
    access(1, 0, 32'h31, '0, 0, 0);
    chk("spurious_hit_stalls", 128'(stall_seen - s0), 128'(0));

    // Reset during WRITEBACK
    access(0, 1, 32'h26, 32'hCAFEF00D, 0, 0);
    proc_read = 1'b1; proc_addr = 30'h06;
    set_exp(1, 0, 0, 0, '0, '0);
    step();
    set_exp(1, 0, 1, 9, mdat[1], '0);
    i_rst = 1'b0;
    step();
    proc_read = 1'b0;
    model_reset();
    set_exp(0, 0, 0, 0, '0, '0);
    i_rst = 1'b1;
    step();
    idle(1, 1'b1);
    idle(1, 1'b0);
    s0 = stall_seen;
    access(1, 0, 32'h26, '0, 0, 1);
    chk("post_rst_stalls", 128'(stall_seen - s0), 128'(3));
    chk("post_rst_rdata", 128'(rd_seen), 128'(32'hC0DE0092));
    idle(2, 1'b0);

    exp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised direct-mapped, write-back, write-allocate data cache placed between the pipelined CPU's MEM stage and the slow data memory. It replaces the fixed single-word `mem_read`/`mem_write`/`mem_ready` path with a line-based interface. It stalls the pipeline on misses, writes back dirty victims and refills whole lines. Hits complete with zero stall cycles.

## Interface
- `LINES`, 8: number of cache lines; power of 2, ≥2.
- `WORDS`, 4: 32-bit words per line; power of 2, ≥1.
- `ADDR_W`, 30: CPU word-address width.
- Derived widths:
  - `IDX = log2(LINES)`
  - `OFF = log2(WORDS)`; a 0-bit field when `WORDS = 1`.
  - `TAG = ADDR_W - IDX - OFF`
- `clk` input 1: rising-edge clock.
- `i_rst` input 1: reset, synchronous, active-low.
- `proc_read` input 1: CPU load request; held stable while `proc_stall` is high.
- `proc_write` input 1: CPU store request; held stable while `proc_stall` is high.
- `proc_addr` input `ADDR_W`: word address, split as tag | index | offset.
- `proc_wdata` input 32: store data.
- `proc_rdata` output 32: load data; valid when `proc_read` is high and `proc_stall` is low.
- `proc_stall` output 1: freeze the pipeline.
- `mem_read` output 1: line refill request.
- `mem_write` output 1: line write-back request.
- `mem_addr` output `ADDR_W-OFF`: line address.
- `mem_wdata` output `32*WORDS`: victim line; word 0 sits in bits [31:0].
- `mem_rdata` input `32*WORDS`: refill line, same packing as `mem_wdata`.
- `mem_ready` input 1: one-cycle pulse; completes the current `mem_read` or `mem_write`.

## Operation
- **Storage per line:** valid, dirty, tag[`TAG`], data[`32*WORDS`].
- **FSM states:** COMPARE, WRITEBACK, ALLOCATE.
- **COMPARE:**
  - A request is active when `proc_read` or `proc_write` is high. If both are high, the request is treated as a write.
  - Hit: the indexed line is valid and its stored tag equals `proc_addr` tag.
  - Read hit: `proc_rdata` = the selected word, combinational. `proc_stall` = 0.
  - Write hit: the selected word ← `proc_wdata` at the clock edge; dirty ← 1. `proc_stall` = 0.
  - Miss on a dirty line: `proc_stall` = 1; next state is WRITEBACK.
  - Miss on a clean or invalid line: `proc_stall` = 1; next state is ALLOCATE.
  - No active request: `proc_stall` = 0; the state does not change.
- **WRITEBACK:**
  - Outputs: `mem_write` = 1, `mem_addr` = {stored tag, index}, `mem_wdata` = the line data.
  - `proc_stall` = 1.
  - On `mem_ready`, next state is ALLOCATE.
- **ALLOCATE:**
  - Outputs: `mem_read` = 1, `mem_addr` = {`proc_addr` tag, index}.
  - `proc_stall` = 1.
  - On `mem_ready`: data ← `mem_rdata`, tag ← request tag, valid ← 1, dirty ← 0; next state is COMPARE.
  - The request then hits in COMPARE. A store merges into the refilled line at that point and sets dirty.
- **Output derivation:**
  - `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are decoded from the state register plus stored line state only. They do not depend combinationally on `mem_ready`.
  - `mem_read` and `mem_write` are never high together.
  - Outside WRITEBACK and ALLOCATE, `mem_read` = 0 and `mem_write` = 0. `mem_addr` and `mem_wdata` are don't-care there but driven to 0.
- **`proc_rdata`:** 0 when there is no read hit.
- **Reset:** all valid and dirty bits ← 0; state ← COMPARE. Data and tag arrays are not reset.
- **Reset mid-operation** (during WRITEBACK or ALLOCATE):
  - The transfer is abandoned and the next state is COMPARE.
  - `mem_read` and `mem_write` drop in the cycle after the reset edge.
  - A late `mem_ready` arriving while in COMPARE is ignored.
- A `mem_ready` pulse outside WRITEBACK or ALLOCATE is ignored.

## Timing
- Reset values: `proc_stall` = 0 with no request, `mem_read` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0, `proc_rdata` = 0.
- Hit: 0 stall cycles; `proc_stall` is combinational from the request and tag compare.
- Clean miss, `mem_ready` arriving R cycles after ALLOCATE is entered (R ≥ 0, counted in the same cycle):
  - `proc_stall` is high for the miss cycle plus R+1 ALLOCATE cycles.
  - It falls in the COMPARE cycle that follows, when the request hits.
- Dirty miss: adds W+1 WRITEBACK cycles, where W is the write-back `mem_ready` delay.
- The line update on `mem_ready` takes effect at that clock edge. The returning COMPARE cycle sees the new line.
- Write-hit dirty set and data write occur at the same edge.

## Test plan
- **Reset:** hold `i_rst` = 0 for 2 cycles with `proc_read` = 1 at addr 0, then release → cold miss; `mem_read` = 1 with `mem_addr` = 0 on the next cycle.
- **Cold read miss, then hit:** read addr 0x05 (LINES = 8, WORDS = 4); memory returns line {0x44, 0x33, 0x22, 0x11} after 3 cycles → stall for 5 cycles, then `proc_rdata` = 0x22. A following read of 0x04 hits with 0 stall and returns 0x11.
- **Write hit, then conflict eviction:**
  - Write 0xDEADBEEF to 0x05 → 0-cycle write hit, dirty set.
  - Read 0x25, same index with a different tag → `mem_write` = 1, `mem_addr` = 0x01, `mem_wdata` word1 = 0xDEADBEEF.
  - Then `mem_read` with `mem_addr` = 0x09.
- **Write miss on a clean line:** allocate, then the store merges → only `mem_read` is issued, no `mem_write`. A later eviction of that line writes back the merged word.
- **`mem_ready` timing:** `mem_ready` asserted in the same cycle ALLOCATE is entered → stall lasts exactly 2 cycles. A spurious `mem_ready` in COMPARE → no state change.
- **Reset mid-operation:** assert `i_rst` = 0 during WRITEBACK → `mem_write` = 0 on the next cycle, all lines invalid, and a re-read of the previously hit address misses.
